// File: rtl/jzjpcc_decode_execute_register.sv
// jzjpcc_decode_execute_register: decode-to-execute pipeline register with bypass capture, bubbles, stall hold and debug counters
module jzjpcc_decode_execute_register #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_execute,
    input  logic             flush_execute,
    input  logic             valid_decode,
    input  logic [XLEN-1:0]  pc_decode,
    input  logic [4:0]       rs1Addr_decode,
    input  logic [4:0]       rs2Addr_decode,
    input  logic [4:0]       rdAddr_decode,
    input  logic [XLEN-1:0]  rs1_decode,
    input  logic [XLEN-1:0]  rs2_decode,
    input  logic             bypassRS1_decode,
    input  logic             bypassRS2_decode,
    input  logic [XLEN-1:0]  bypassValueRS1_decode,
    input  logic [XLEN-1:0]  bypassValueRS2_decode,
    input  logic [XLEN-1:0]  imm_decode,
    input  logic [3:0]       aluOp_decode,
    input  logic             rdWriteEnable_decode,
    input  logic             rdSource_decode,
    input  logic             memWrite_decode,
    output logic             valid_execute,
    output logic [XLEN-1:0]  pc_execute,
    output logic [XLEN-1:0]  rs1_execute,
    output logic [XLEN-1:0]  rs2_execute,
    output logic [XLEN-1:0]  imm_execute,
    output logic [4:0]       rs1Addr_execute,
    output logic [4:0]       rs2Addr_execute,
    output logic [4:0]       rdAddr_execute,
    output logic [3:0]       aluOp_execute,
    output logic             rdWriteEnable_execute,
    output logic             rdSource_execute,
    output logic             memWrite_execute,
    output logic [CNT_W-1:0] bubbleCount,
    output logic [CNT_W-1:0] issueCount,
    output logic             stallTimeout
);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [SW-1:0]   stall_cnt;
    logic [SW-1:0]   stall_next;
    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;

    // x0 always reads zero, so bypass data is never taken for it
    assign rs1_sel    = (rs1Addr_decode == 5'd0) ? '0 : bypassRS1_decode ? bypassValueRS1_decode : rs1_decode;
    assign rs2_sel    = (rs2Addr_decode == 5'd0) ? '0 : bypassRS2_decode ? bypassValueRS2_decode : rs2_decode;
    assign stall_next = (stall_cnt == SW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            {valid_execute, pc_execute, rs1_execute, rs2_execute, imm_execute, rs1Addr_execute,
             rs2Addr_execute, rdAddr_execute, aluOp_execute, rdWriteEnable_execute,
             rdSource_execute, memWrite_execute} <= '0;
            bubbleCount  <= '0;
            issueCount   <= '0;
            stall_cnt    <= '0;
            stallTimeout <= 1'b0;
        end else if (flush_execute) begin
            {valid_execute, pc_execute, rs1_execute, rs2_execute, imm_execute, rs1Addr_execute,
             rs2Addr_execute, rdAddr_execute, aluOp_execute, rdWriteEnable_execute,
             rdSource_execute, memWrite_execute} <= '0;
            bubbleCount  <= bubbleCount + CNT_W'(bubbleCount != '1);
            stall_cnt    <= '0;
            stallTimeout <= 1'b0;
        end else if (stall_execute) begin
            stall_cnt    <= stall_next;
            stallTimeout <= (stall_next == SW'(STALL_LIMIT));
        end else begin
            valid_execute         <= valid_decode;
            pc_execute            <= pc_decode;
            rs1_execute           <= rs1_sel;
            rs2_execute           <= rs2_sel;
            imm_execute           <= imm_decode;
            rs1Addr_execute       <= rs1Addr_decode;
            rs2Addr_execute       <= rs2Addr_decode;
            rdAddr_execute        <= rdAddr_decode;
            aluOp_execute         <= aluOp_decode;
            rdWriteEnable_execute <= valid_decode & rdWriteEnable_decode;
            rdSource_execute      <= valid_decode & rdSource_decode;
            memWrite_execute      <= valid_decode & memWrite_decode;
            issueCount            <= issueCount + CNT_W'(valid_decode && issueCount != '1);
            stall_cnt             <= '0;
            stallTimeout          <= 1'b0;
        end
    end
endmodule

// File: tb/tb_jzjpcc_decode_execute_register.sv
// tb_jzjpcc_decode_execute_register: directed bench with hand-computed expectations (CNT_W=4, STALL_LIMIT=4)
module tb_jzjpcc_decode_execute_register;
    logic        clock = 1'b0;
    logic        reset, stall_execute, flush_execute, valid_decode;
    logic [31:0] pc_decode, rs1_decode, rs2_decode, bypassValueRS1_decode, bypassValueRS2_decode, imm_decode;
    logic [4:0]  rs1Addr_decode, rs2Addr_decode, rdAddr_decode;
    logic        bypassRS1_decode, bypassRS2_decode;
    logic [3:0]  aluOp_decode;
    logic        rdWriteEnable_decode, rdSource_decode, memWrite_decode;
    logic        valid_execute;
    logic [31:0] pc_execute, rs1_execute, rs2_execute, imm_execute;
    logic [4:0]  rs1Addr_execute, rs2Addr_execute, rdAddr_execute;
    logic [3:0]  aluOp_execute;
    logic        rdWriteEnable_execute, rdSource_execute, memWrite_execute;
    logic [3:0]  bubbleCount, issueCount;
    logic        stallTimeout;
    int          checks = 0;
    int          errors = 0;

    jzjpcc_decode_execute_register #(.XLEN(32), .CNT_W(4), .STALL_LIMIT(4)) dut (
        .clock(clock), .reset(reset), .stall_execute(stall_execute), .flush_execute(flush_execute),
        .valid_decode(valid_decode), .pc_decode(pc_decode), .rs1Addr_decode(rs1Addr_decode),
        .rs2Addr_decode(rs2Addr_decode), .rdAddr_decode(rdAddr_decode), .rs1_decode(rs1_decode),
        .rs2_decode(rs2_decode), .bypassRS1_decode(bypassRS1_decode), .bypassRS2_decode(bypassRS2_decode),
        .bypassValueRS1_decode(bypassValueRS1_decode), .bypassValueRS2_decode(bypassValueRS2_decode),
        .imm_decode(imm_decode), .aluOp_decode(aluOp_decode), .rdWriteEnable_decode(rdWriteEnable_decode),
        .rdSource_decode(rdSource_decode), .memWrite_decode(memWrite_decode),
        .valid_execute(valid_execute), .pc_execute(pc_execute), .rs1_execute(rs1_execute),
        .rs2_execute(rs2_execute), .imm_execute(imm_execute), .rs1Addr_execute(rs1Addr_execute),
        .rs2Addr_execute(rs2Addr_execute), .rdAddr_execute(rdAddr_execute), .aluOp_execute(aluOp_execute),
        .rdWriteEnable_execute(rdWriteEnable_execute), .rdSource_execute(rdSource_execute),
        .memWrite_execute(memWrite_execute), .bubbleCount(bubbleCount), .issueCount(issueCount),
        .stallTimeout(stallTimeout)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; stall_execute = 1'b0; flush_execute = 1'b0; valid_decode = 1'b0;
        pc_decode = '0; rs1_decode = '0; rs2_decode = '0; bypassValueRS1_decode = '0;
        bypassValueRS2_decode = '0; imm_decode = '0; rs1Addr_decode = '0; rs2Addr_decode = '0;
        rdAddr_decode = '0; bypassRS1_decode = 1'b0; bypassRS2_decode = 1'b0; aluOp_decode = '0;
        rdWriteEnable_decode = 1'b0; rdSource_decode = 1'b0; memWrite_decode = 1'b0;
        step();
        valid_decode = 1'b1; pc_decode = 32'h100; rdAddr_decode = 5'd5; rdWriteEnable_decode = 1'b1;
        memWrite_decode = 1'b1; rdSource_decode = 1'b1; imm_decode = 32'hABC; aluOp_decode = 4'h7;
        flush_execute = 1'b1;
        step();
        chk("rst_valid", 32'(valid_execute), 32'd0);
        chk("rst_pc", pc_execute, 32'h0);
        chk("rst_bubble", 32'(bubbleCount), 32'd0);
        chk("rst_issue", 32'(issueCount), 32'd0);
        chk("rst_we", 32'(rdWriteEnable_execute), 32'd0);
        chk("rst_timeout", 32'(stallTimeout), 32'd0);
        reset = 1'b1; flush_execute = 1'b0;
        step();
        chk("ld_pc", pc_execute, 32'h100);
        chk("ld_rd", 32'(rdAddr_execute), 32'd5);
        chk("ld_valid", 32'(valid_execute), 32'd1);
        chk("ld_we", 32'(rdWriteEnable_execute), 32'd1);
        chk("ld_mem", 32'(memWrite_execute), 32'd1);
        chk("ld_src", 32'(rdSource_execute), 32'd1);
        chk("ld_imm", imm_execute, 32'hABC);
        chk("ld_alu", 32'(aluOp_execute), 32'h7);
        chk("ld_issue", 32'(issueCount), 32'd1);
        chk("ld_bubble", 32'(bubbleCount), 32'd0);
        memWrite_decode = 1'b0; rdSource_decode = 1'b0;
        rs1Addr_decode = 5'd3; rs1_decode = 32'h11; bypassRS1_decode = 1'b1; bypassValueRS1_decode = 32'h22;
        rs2Addr_decode = 5'd4; rs2_decode = 32'h33; bypassRS2_decode = 1'b0; bypassValueRS2_decode = 32'h44;
        step();
        chk("byp_rs1", rs1_execute, 32'h22);
        chk("nobyp_rs2", rs2_execute, 32'h33);
        chk("byp_rs1addr", 32'(rs1Addr_execute), 32'd3);
        rs1Addr_decode = 5'd0; rs2Addr_decode = 5'd0; bypassRS2_decode = 1'b1;
        step();
        chk("x0_rs1", rs1_execute, 32'h0);
        chk("x0_rs2", rs2_execute, 32'h0);
        chk("x0_issue", 32'(issueCount), 32'd3);
        pc_decode = 32'h200;
        step();
        chk("a_pc", pc_execute, 32'h200);
        chk("a_issue", 32'(issueCount), 32'd4);
        pc_decode = 32'h204; stall_execute = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_execute, 32'h200);
            chk("stall_issue", 32'(issueCount), 32'd4);
            chk("stall3_timeout", 32'(stallTimeout), 32'd0);
        end
        stall_execute = 1'b0;
        step();
        chk("rel_pc", pc_execute, 32'h204);
        chk("rel_issue", 32'(issueCount), 32'd5);
        stall_execute = 1'b1; flush_execute = 1'b1; rdAddr_decode = 5'd5; rdWriteEnable_decode = 1'b1;
        step();
        chk("fl_valid", 32'(valid_execute), 32'd0);
        chk("fl_we", 32'(rdWriteEnable_execute), 32'd0);
        chk("fl_rd", 32'(rdAddr_execute), 32'd0);
        chk("fl_pc", pc_execute, 32'h0);
        chk("fl_bubble", 32'(bubbleCount), 32'd1);
        chk("fl_timeout", 32'(stallTimeout), 32'd0);
        chk("fl_issue", 32'(issueCount), 32'd5);
        flush_execute = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("wd_timeout", 32'(stallTimeout), (i >= 4) ? 32'd1 : 32'd0);
        end
        stall_execute = 1'b0;
        step();
        chk("wd_clear", 32'(stallTimeout), 32'd0);
        chk("wd_issue", 32'(issueCount), 32'd6);
        valid_decode = 1'b0; rdWriteEnable_decode = 1'b1; memWrite_decode = 1'b1; rdSource_decode = 1'b1;
        step();
        chk("inv_valid", 32'(valid_execute), 32'd0);
        chk("inv_we", 32'(rdWriteEnable_execute), 32'd0);
        chk("inv_mem", 32'(memWrite_execute), 32'd0);
        chk("inv_src", 32'(rdSource_execute), 32'd0);
        chk("inv_issue", 32'(issueCount), 32'd6);
        valid_decode = 1'b1;
        for (int i = 0; i < 9; i++) step();
        chk("sat_15", 32'(issueCount), 32'hF);
        for (int i = 0; i < 3; i++) step();
        chk("sat_hold", 32'(issueCount), 32'hF);
        stall_execute = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_timeout", 32'(stallTimeout), 32'd1);
        reset = 1'b0;
        step();
        chk("mrst_valid", 32'(valid_execute), 32'd0);
        chk("mrst_pc", pc_execute, 32'h0);
        chk("mrst_issue", 32'(issueCount), 32'd0);
        chk("mrst_bubble", 32'(bubbleCount), 32'd0);
        chk("mrst_timeout", 32'(stallTimeout), 32'd0);
        reset = 1'b1; stall_execute = 1'b0; pc_decode = 32'h300;
        step();
        chk("post_pc", pc_execute, 32'h300);
        chk("post_valid", 32'(valid_execute), 32'd1);
        chk("post_issue", 32'(issueCount), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jzjpcc_decode_execute_register.md
Name: jzjpcc_decode_execute_register

Overview:
- Decode→execute pipeline register of the jzjpcc core; the consumer of the hazard unit's flush_execute and decode-bypass outputs.
- Captures decoded fields and operands each cycle. Applies decode-stage bypass muxing and x0 forcing at capture.
- Inserts bubbles on flush and holds contents on stall.
- Keeps bubble/instruction counters and a stall watchdog for debug.

Parameters:
- XLEN, 32, operand/immediate/PC width.
- CNT_W, 32, width of bubble and issued-instruction counters.
- STALL_LIMIT, 16, consecutive held cycles before stallTimeout asserts; must be ≥1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- stall_execute  in  1  hold current contents
- flush_execute  in  1  load bubble
- valid_decode  in  1  decode holds a real instruction
- pc_decode  in  XLEN  instruction PC
- rs1Addr_decode, rs2Addr_decode, rdAddr_decode  in  5 each  register addresses
- rs1_decode, rs2_decode  in  XLEN  register-file read values
- bypassRS1_decode, bypassRS2_decode  in  1  use bypass value
- bypassValueRS1_decode, bypassValueRS2_decode  in  XLEN  bypass data
- imm_decode  in  XLEN  immediate
- aluOp_decode  in  4  ALU operation
- rdWriteEnable_decode, rdSource_decode, memWrite_decode  in  1 each  control bits
- valid_execute  out  1  execute holds a real instruction
- pc_execute, rs1_execute, rs2_execute, imm_execute  out  XLEN  registered copies
- rs1Addr_execute, rs2Addr_execute, rdAddr_execute  out  5 each
- aluOp_execute  out  4
- rdWriteEnable_execute, rdSource_execute, memWrite_execute  out  1 each
- bubbleCount  out  CNT_W  bubbles inserted
- issueCount  out  CNT_W  valid instructions captured
- stallTimeout  out  1  watchdog flag

Behaviour:
- Reset (reset=0 at rising edge): every output register goes to 0, including valid_execute, counters, stall counter and stallTimeout. Reset overrides stall and flush.
- Per-edge priority: reset > flush_execute > stall_execute > normal load.
- Flush: valid, rdWriteEnable, memWrite, rdSource go to 0. Addresses go to 0, so the hazard unit sees no write. Data fields go to 0. bubbleCount increments.
- Stall (no flush): all pipeline outputs hold. Stall counter increments.
- Normal load: all fields captured from decode, 1-cycle latency.
  - Operand rsN_execute = 0 if rsNAddr_decode==0. Otherwise bypassValueRSN_decode if bypassRSN_decode=1. Otherwise rsN_decode.
  - Bypass is ignored for x0.
  - If valid_decode=0, control write bits are forced to 0. issueCount increments only when valid_decode=1.
- Control gating: rdWriteEnable/memWrite/rdSource outputs are 0 whenever valid_execute=0. Maintained by the capture rule, not by output gating.
- Counters: bubbleCount and issueCount saturate at all-ones, no wrap.
- Stall watchdog: consecutive-stall counter, saturating, width clog2(STALL_LIMIT+1).
  - Cleared on any non-stall edge (flush or normal load).
  - stallTimeout is registered. It asserts on the edge where the counter reaches STALL_LIMIT.
  - Stays 1 while the stall persists. Clears on the first non-stall edge.
- Simultaneous stall+flush: flush wins; bubble counted, stall counter cleared.
- Reset mid-stall: the next edge with reset=1 and no stall/flush performs a normal load.

Test Plan:
- Reset low 2 cycles, then reset high with valid_decode=1, pc_decode=0x100, rd=5, rdWriteEnable=1 → next cycle: pc_execute=0x100, rdAddr_execute=5, valid=1, issueCount=1; bubbleCount=0 throughout reset.
- Load rs1Addr=3, rs1_decode=0x11, bypassRS1=1, bypassValue=0x22 → rs1_execute=0x22. Repeat with rs1Addr=0, bypassRS1=1 → rs1_execute=0.
- Capture instruction A (pc 0x200), then assert stall 3 cycles while decode presents pc 0x204 → pc_execute stays 0x200 for 3 cycles, then 0x204 after release; issueCount +2 total.
- Assert flush and stall together with valid rdWriteEnable=1 input → valid_execute=0, rdWriteEnable_execute=0, rdAddr_execute=0, bubbleCount+1, stallTimeout=0.
- STALL_LIMIT=4, hold stall 6 cycles → stallTimeout rises after the 4th stalled edge, stays high through the 6th, drops on the first normal-load edge.
- Preload issueCount near all-ones (CNT_W=4 build, 16 valid loads) → saturates at 0xF. Assert reset mid-stall → all outputs 0 next edge.
